// File: rtl/sram_like_responder.sv
// Data-side SRAM-like slave: addr_ok/data_ok handshake with in-order, fixed-latency
// completions queued in a small circular FIFO, backed by a word-addressed array.
module sram_like_responder #(
    parameter int MEM_AW = 10,
    parameter int LAT    = 2,
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_throttle,
    output logic        o_addr_ok,
    output logic        o_data_ok,
    output logic [31:0] o_rdata
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int TW = 4;

    logic [31:0]       r_mem   [2**MEM_AW];
    logic [QDEPTH-1:0] r_vld;
    logic              r_wr    [QDEPTH];
    logic [31:0]       r_data  [QDEPTH];
    logic [TW-1:0]     r_timer [QDEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic [MEM_AW-1:0] w_idx;
    logic              w_accept;
    logic              w_retire;
    logic              w_unused;

    // Size and sub-word address bits never reach the array; upper bits alias.
    assign w_unused = ^{i_addr[31:MEM_AW+2], i_addr[1:0], i_size};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(QDEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Handshake decode and head-of-queue completion outputs
    always_comb begin
        w_idx     = i_addr[MEM_AW+1:2];
        w_retire  = r_vld[r_head] && (r_timer[r_head] == '0);
        o_addr_ok = ~reset & ~i_throttle & (r_count < CW'(QDEPTH));
        w_accept  = i_req & o_addr_ok;
        o_data_ok = ~reset & w_retire;
        if (o_data_ok && !r_wr[r_head]) begin
            o_rdata = r_data[r_head];
        end else begin
            o_rdata = 32'h0000_0000;
        end
    end

    // Array write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_accept && i_wr && i_wstrb[i]) begin
                r_mem[w_idx][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    // Transaction FIFO: push on accept, pop on retire, per-entry latency timers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_wr[i]    <= 1'b0;
                r_data[i]  <= 32'h0000_0000;
                r_timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (r_vld[i] && (r_timer[i] != '0)) begin
                    r_timer[i] <= r_timer[i] - TW'(1);
                end
            end
            if (w_retire) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= ptr_inc(r_head);
            end
            // The tail slot is always free when accepting, so it never collides with the head pop.
            if (w_accept) begin
                r_vld[r_tail]   <= 1'b1;
                r_wr[r_tail]    <= i_wr;
                r_data[r_tail]  <= r_mem[w_idx];
                r_timer[r_tail] <= TW'(LAT - 1);
                r_tail          <= ptr_inc(r_tail);
            end
            if (w_accept && !w_retire) begin
                r_count <= r_count + CW'(1);
            end else if (!w_accept && w_retire) begin
                r_count <= r_count - CW'(1);
            end
        end
    end
endmodule
